// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, start/busy/done handshake.
// Optional abort input enabled by defining SERIAL_ADDSUB_ABORT_EN.
module serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADDSUB_ABORT_EN
  input  logic             abort,
`endif
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_r_sr;
  logic               r_carry;
  logic               r_mode;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_overflow;

  logic               w_abort;
  logic               w_accept;
  logic               w_last;
  logic [DIGIT-1:0]   w_sum;
  logic [DIGIT:0]     w_c;
  logic [WIDTH+DIGIT-1:0] w_r_cat;
  logic [WIDTH-1:0]   w_r_next;

`ifdef SERIAL_ADDSUB_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_last = (r_count == CW'(STEPS - 1));

  // Ripple carry across one digit; w_c[DIGIT-1] is the carry into the MSB on the last step.
  always_comb begin
    w_sum  = '0;
    w_c    = '0;
    w_c[0] = r_carry;
    for (int i = 0; i < DIGIT; i++) begin
      w_sum[i]  = r_a_sr[i] ^ r_b_sr[i] ^ w_c[i];
      w_c[i+1]  = (r_a_sr[i] & r_b_sr[i]) | (r_a_sr[i] & w_c[i]) | (r_b_sr[i] & w_c[i]);
    end
  end

  // Sum digits enter from the MSB side so the first digit ends up at bit 0.
  assign w_r_cat  = {w_sum, r_r_sr};
  assign w_r_next = w_r_cat[WIDTH+DIGIT-1:DIGIT];

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start && !w_abort) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_abort)     w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_r_sr     <= '0;
      r_carry    <= 1'b0;
      r_mode     <= 1'b0;
      r_count    <= '0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        // Subtraction is a + ~b + ~borrow on the same adder.
        r_a_sr  <= a;
        r_b_sr  <= mode ? ~b : b;
        r_carry <= mode ? ~cin : cin;
        r_mode  <= mode;
        r_r_sr  <= '0;
        r_count <= '0;
      end else if (r_state == S_RUN && !w_abort) begin
        r_a_sr  <= r_a_sr >> DIGIT;
        r_b_sr  <= r_b_sr >> DIGIT;
        r_r_sr  <= w_r_next;
        r_carry <= w_c[DIGIT];
        r_count <= r_count + CW'(1);
        if (w_last) begin
          r_result   <= w_r_next;
          r_cout     <= r_mode ? ~w_c[DIGIT] : w_c[DIGIT];
          r_overflow <= w_c[DIGIT-1] ^ w_c[DIGIT];
        end
      end
    end
  end

  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_overflow;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: DIGIT=1 and DIGIT=4 instances, WIDTH=32.
// Latency counts edges including the accept edge (STEPS+1).
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;

  logic [31:0] res1, res4;
  logic        cout1, cout4, ovf1, ovf4, busy1, busy4, done1, done4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .start(start1),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort(abort),
`endif
    .mode(mode), .a(a), .b(b), .cin(cin),
    .result(res1), .cout(cout1), .overflow(ovf1), .busy(busy1), .done(done1)
  );

  serial_addsub #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .reset(reset), .start(start4),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort(1'b0),
`endif
    .mode(mode), .a(a), .b(b), .cin(cin),
    .result(res4), .cout(cout4), .overflow(ovf4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] g_res(input int sel);  return sel ? res4  : res1;  endfunction
  function automatic logic        g_cout(input int sel); return sel ? cout4 : cout1; endfunction
  function automatic logic        g_ovf(input int sel);  return sel ? ovf4  : ovf1;  endfunction
  function automatic logic        g_busy(input int sel); return sel ? busy4 : busy1; endfunction
  function automatic logic        g_done(input int sel); return sel ? done4 : done1; endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel) start4 = v; else start1 = v;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where done is high (state DONE).
  task automatic run_op(input string tag, input int sel, input logic m,
                        input logic [31:0] av, input logic [31:0] bv, input logic ci,
                        input logic [31:0] er, input logic ec, input logic eo,
                        input logic [31:0] prev, input int mid_start);
    int  n;
    bit  seen;
    int  steps;
    steps = sel ? 8 : 32;
    mode = m; a = av; b = bv; cin = ci;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    // Scramble inputs: they must not be re-sampled after accept.
    a = ~av; b = 32'h5A5A_5A5A; cin = ~ci; mode = ~m;
    check({tag, "_busy_run"}, 32'(g_busy(sel)), 32'd1);
    check({tag, "_done_low"}, 32'(g_done(sel)), 32'd0);
    n = 1;
    seen = 0;
    while (!seen && n < 100) begin
      if (n == mid_start) set_start(sel, 1'b1);
      tick();
      set_start(sel, 1'b0);
      n++;
      if (g_done(sel)) seen = 1;
      else if (g_busy(sel)) check({tag, "_held"}, g_res(sel), prev);
    end
    check({tag, "_latency"}, 32'(n), 32'(steps + 1));
    check({tag, "_result"}, g_res(sel), er);
    check({tag, "_cout"}, 32'(g_cout(sel)), 32'(ec));
    check({tag, "_ovf"}, 32'(g_ovf(sel)), 32'(eo));
    check({tag, "_busy_done"}, 32'(g_busy(sel)), 32'd0);
    $display("op %s: result=%h cout=%0b ovf=%0b latency=%0d", tag, g_res(sel), g_cout(sel), g_ovf(sel), n);
  endtask

  task automatic go_idle(input string tag, input int sel, input logic [31:0] held);
    tick();
    check({tag, "_done_pulse"}, 32'(g_done(sel)), 32'd0);
    check({tag, "_idle_busy"}, 32'(g_busy(sel)), 32'd0);
    check({tag, "_idle_held"}, g_res(sel), held);
  endtask

  initial begin
    int  dn;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    check("rst_result", res1, 32'h0);
    check("rst_flags", {28'h0, cout1, ovf1, busy1, done1}, 32'h0);
    check("rst_result4", res4, 32'h0);

    run_op("sub50_20", 0, 1'b1, 32'd50, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 32'h0, 0);
    // Back-to-back from DONE, with a start pulse during RUN that must be ignored.
    run_op("sub0_15", 0, 1'b1, 32'd0, 32'd15, 1'b0, 32'hFFFF_FFF1, 1'b1, 1'b0, 32'd30, 12);
    go_idle("sub0_15", 0, 32'hFFFF_FFF1);
    run_op("sub200_100", 0, 1'b1, 32'd200, 32'd100, 1'b1, 32'd99, 1'b0, 1'b0, 32'hFFFF_FFF1, 0);
    run_op("add_max_pos", 0, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'd99, 0);
    run_op("add_wrap", 0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 0);
    go_idle("add_wrap", 0, 32'h0);

    run_op("d4_add", 1, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 32'h0, 0);
    run_op("d4_sub", 1, 1'b1, 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h2345_6789, 0);
    go_idle("d4_sub", 1, 32'h7FFF_FFFF);

    run_op("add5_6", 0, 1'b0, 32'd5, 32'd6, 1'b0, 32'd11, 1'b0, 1'b0, 32'h0, 0);
    go_idle("add5_6", 0, 32'd11);

    // Reset at step 10 aborts the operation and clears outputs.
    mode = 1'b0; a = 32'hFFFF_FFFF; b = 32'd1; cin = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rst10_busy_before", 32'(busy1), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst10_result", res1, 32'h0);
    check("rst10_flags", {28'h0, cout1, ovf1, busy1, done1}, 32'h0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done1) dn++;
    end
    check("rst10_no_done", 32'(dn), 32'd0);
    $display("op reset_at_step10: result=%h busy=%0b", res1, busy1);

`ifdef SERIAL_ADDSUB_ABORT_EN
    run_op("add100_23", 0, 1'b0, 32'd100, 32'd23, 1'b0, 32'd123, 1'b0, 1'b0, 32'h0, 0);
    go_idle("add100_23", 0, 32'd123);
    mode = 1'b0; a = 32'd1; b = 32'd1; cin = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy1), 32'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done1) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    check("abort_held", res1, 32'd123);
    // abort beats start in IDLE.
    abort = 1'b1;
    start1 = 1'b1;
    tick();
    abort = 1'b0;
    start1 = 1'b0;
    check("abort_wins_start", 32'(busy1), 32'd0);
    $display("op abort_at_step5: result=%h busy=%0b", res1, busy1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
